// File: rtl/gyro_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// gyro_integrator: N-channel windowed rate-gyro integrator with persistent modulo-360 angles.
// Optional feature macro: GYRO_BIAS_CAL_EN (bias calibration). Rev 1.0
// ---------------------------------------------------------------------------------------------
module gyro_integrator #(
   parameter int NUM_CH      = 3,
   parameter int IN_W        = 16,
   parameter int WINDOW      = 10000,
   parameter int SCALE_MUL   = 7,
   parameter int SCALE_SHIFT = 16,
   parameter int FRAC_W      = 8
) (
   input  logic                   clk_100mhz,
   input  logic                   rst_n_in,
`ifdef GYRO_BIAS_CAL_EN
   input  logic                   cal_start_in,
   output logic                   cal_busy_out,
`endif
   input  logic [NUM_CH*IN_W-1:0] gyro_in,
   input  logic                   sample_valid_in,
   input  logic                   zero_in,
   output logic [NUM_CH*9-1:0]    angle_out,
   output logic                   angle_valid_out,
   output logic                   sat_out,
   output logic                   overrun_out
);
   localparam int ACC_W  = IN_W + $clog2(WINDOW) + 1;
   localparam int CNT_W  = $clog2(WINDOW + 1);
   localparam int FULL   = 360 << FRAC_W;
   localparam int ANG_W  = $clog2(FULL);
   localparam int DLT_W  = ANG_W + 1;
   localparam int SUM_W  = ANG_W + 2;
   localparam int PROD_W = ACC_W + 33;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic signed [32:0]       C_MUL  = 33'(SCALE_MUL);
   localparam logic signed [PROD_W-1:0] C_DMAX = PROD_W'(FULL - 1);
   localparam logic signed [DLT_W-1:0]  C_DLIM = DLT_W'(FULL - 1);
   localparam logic signed [SUM_W-1:0]  C_FULL = SUM_W'(FULL);

   typedef enum logic [1:0] {IDLE, MUL, WRAP, PUBLISH} state_t;

   state_t                    state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic signed [ACC_W-1:0]   acc_q [NUM_CH];
   logic signed [ACC_W-1:0]   acc_d [NUM_CH];
   logic signed [ACC_W-1:0]   snap_q [NUM_CH];
   logic signed [ACC_W-1:0]   snap_d [NUM_CH];
   logic [ANG_W-1:0]          angle_q [NUM_CH];
   logic [ANG_W-1:0]          angle_d [NUM_CH];
   logic signed [DLT_W-1:0]   delta_q, delta_d;
   logic [NUM_CH*9-1:0]       angle_out_q, angle_out_d;
   logic                      valid_q, valid_d;
   logic                      sat_q, sat_d;
   logic                      ovr_q, ovr_d;

   logic signed [PROD_W-1:0]  prod, scaled;
   logic signed [SUM_W-1:0]   sum;
   logic signed [ACC_W-1:0]   w_samp [NUM_CH];
   logic signed [IN_W-1:0]    w_bias [NUM_CH];
   logic                      w_cal_start, w_cal_busy, w_zero, w_close;

   assign w_zero  = zero_in | w_cal_start;
   assign w_close = sample_valid_in && (count_q == CNT_W'(WINDOW - 1)) && !w_zero;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_samp
      assign w_samp[k] = ACC_W'($signed(gyro_in[k*IN_W +: IN_W])) - ACC_W'(w_bias[k]);
   end

`ifdef GYRO_BIAS_CAL_EN
   logic signed [IN_W-1:0]    bias_q [NUM_CH];
   logic signed [IN_W-1:0]    bias_d [NUM_CH];
   logic                      cal_busy_q, cal_busy_d;
   localparam logic signed [ACC_W-1:0] C_WIN = ACC_W'(WINDOW);

   // The calibration window measures raw samples, so bias is cleared when it starts.
   always_comb begin
      bias_d     = bias_q;
      cal_busy_d = cal_busy_q;
      if (cal_start_in) begin
         cal_busy_d = 1'b1;
         for (int k = 0; k < NUM_CH; k++) bias_d[k] = '0;
      end else if (w_close && cal_busy_q) begin
         cal_busy_d = 1'b0;
         for (int k = 0; k < NUM_CH; k++) bias_d[k] = IN_W'((acc_q[k] + w_samp[k]) / C_WIN);
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bias_q     <= '{default: '0};
         cal_busy_q <= 1'b0;
      end else begin
         bias_q     <= bias_d;
         cal_busy_q <= cal_busy_d;
      end
   end

   assign w_cal_start  = cal_start_in;
   assign w_cal_busy   = cal_busy_q;
   assign cal_busy_out = cal_busy_q;
   for (genvar k = 0; k < NUM_CH; k++) begin : g_bias
      assign w_bias[k] = bias_q[k];
   end
`else
   assign w_cal_start = 1'b0;
   assign w_cal_busy  = 1'b0;
   for (genvar k = 0; k < NUM_CH; k++) begin : g_bias
      assign w_bias[k] = '0;
   end
`endif

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      count_d     = count_q;
      acc_d       = acc_q;
      snap_d      = snap_q;
      angle_d     = angle_q;
      delta_d     = delta_q;
      angle_out_d = angle_out_q;
      valid_d     = 1'b0;
      sat_d       = sat_q;
      ovr_d       = ovr_q;
      prod        = '0;
      scaled      = '0;
      sum         = '0;

      case (state_q)
         MUL: begin
            prod   = PROD_W'(snap_q[ch_q]) * PROD_W'(C_MUL);
            scaled = prod >>> SCALE_SHIFT;
            if (scaled > C_DMAX) begin
               delta_d = C_DLIM;
               sat_d   = 1'b1;
            end else if (scaled < -C_DMAX) begin
               delta_d = -C_DLIM;
               sat_d   = 1'b1;
            end else begin
               delta_d = DLT_W'(scaled);
            end
            state_d = WRAP;
         end
         WRAP: begin
            // |delta| < FULL, so a single add or subtract brings the angle back into range.
            sum = SUM_W'($signed({1'b0, angle_q[ch_q]})) + SUM_W'(delta_q);
            if (sum[SUM_W-1])       angle_d[ch_q] = ANG_W'(sum + C_FULL);
            else if (sum >= C_FULL) angle_d[ch_q] = ANG_W'(sum - C_FULL);
            else                    angle_d[ch_q] = ANG_W'(sum);
            if (int'(ch_q) + 1 < NUM_CH) begin
               ch_d    = ch_q + CH_W'(1);
               state_d = MUL;
            end else begin
               state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            for (int k = 0; k < NUM_CH; k++) angle_out_d[k*9 +: 9] = 9'(angle_q[k] >> FRAC_W);
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: ;
      endcase

      if (sample_valid_in) begin
         if (w_close) begin
            count_d = '0;
            if (!w_cal_busy) begin
               if (state_q != IDLE) begin
                  ovr_d = 1'b1;
               end else begin
                  state_d = MUL;
                  ch_d    = '0;
                  for (int k = 0; k < NUM_CH; k++) snap_d[k] = acc_q[k] + w_samp[k];
               end
            end
            for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
            for (int k = 0; k < NUM_CH; k++) acc_d[k] = acc_q[k] + w_samp[k];
         end
      end

      if (w_zero) begin
         state_d     = IDLE;
         ch_d        = '0;
         count_d     = '0;
         angle_out_d = '0;
         valid_d     = 1'b1;
         for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k]   = '0;
            snap_d[k]  = '0;
            angle_d[k] = '0;
         end
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         count_q     <= '0;
         acc_q       <= '{default: '0};
         snap_q      <= '{default: '0};
         angle_q     <= '{default: '0};
         delta_q     <= '0;
         angle_out_q <= '0;
         valid_q     <= 1'b0;
         sat_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         snap_q      <= snap_d;
         angle_q     <= angle_d;
         delta_q     <= delta_d;
         angle_out_q <= angle_out_d;
         valid_q     <= valid_d;
         sat_q       <= sat_d;
         ovr_q       <= ovr_d;
      end
   end

   assign angle_out       = angle_out_q;
   assign angle_valid_out = valid_q;
   assign sat_out         = sat_q;
   assign overrun_out     = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_gyro_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// tb_gyro_integrator: randomized bench with a window-level reference model. Rev 1.0
// ---------------------------------------------------------------------------------------------
module tb_gyro_integrator;
   localparam int NCH  = 3;
   localparam int IW   = 16;
   localparam int WIN  = 8;
   localparam int MULV = 1;
   localparam int SH   = 0;
   localparam int FR   = 0;
   localparam int FULL = 360 << FR;
   localparam int LAT  = 2 * NCH + 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NCH*IW-1:0]  gyro = '0;
   logic               sv = 1'b0, zr = 1'b0;
   logic [NCH*9-1:0]   aout;
   logic               aval, sat, ovr;

   logic [47:0]        d_gyro = '0;
   logic               d_sv = 1'b0, d_zr = 1'b0;
   logic [26:0]        d_aout;
   logic               d_aval, d_sat, d_ovr;
`ifdef GYRO_BIAS_CAL_EN
   logic               cal_m = 1'b0, busy_m, d_cal = 1'b0, d_busy;
`endif

   always #5 clk = ~clk;

   gyro_integrator #(.NUM_CH(NCH), .IN_W(IW), .WINDOW(WIN), .SCALE_MUL(MULV),
                     .SCALE_SHIFT(SH), .FRAC_W(FR)) dut (
      .clk_100mhz(clk), .rst_n_in(rst_n),
`ifdef GYRO_BIAS_CAL_EN
      .cal_start_in(cal_m), .cal_busy_out(busy_m),
`endif
      .gyro_in(gyro), .sample_valid_in(sv), .zero_in(zr),
      .angle_out(aout), .angle_valid_out(aval), .sat_out(sat), .overrun_out(ovr));

   gyro_integrator dut_def (
      .clk_100mhz(clk), .rst_n_in(rst_n),
`ifdef GYRO_BIAS_CAL_EN
      .cal_start_in(d_cal), .cal_busy_out(d_busy),
`endif
      .gyro_in(d_gyro), .sample_valid_in(d_sv), .zero_in(d_zr),
      .angle_out(d_aout), .angle_valid_out(d_aval), .sat_out(d_sat), .overrun_out(d_ovr));

   int  vec = 0, miss = 0, pulses = 0;
   bit  chk_en = 1'b0;

   // Reference model: whole-window arithmetic, publish scheduled LAT edges after the close.
   int     cyc = 0;
   int     g_cur [NCH];
   int     m_ang [NCH], m_sum [NCH], pub_ang [NCH], exp_out [NCH];
   int     m_cnt = 0, last_close = -1000, pub_time = 0;
   bit     pub_pend = 1'b0, exp_val = 1'b0, exp_sat = 1'b0, exp_ovr = 1'b0;
   int     sat_t [$];
   longint d;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            m_ang[k] = 0; m_sum[k] = 0; exp_out[k] = 0;
         end
         m_cnt = 0; last_close = -1000; pub_pend = 0;
         exp_val = 0; exp_sat = 0; exp_ovr = 0;
         sat_t.delete();
      end else begin
         cyc++;
         exp_val = 0;
         if (pub_pend && pub_time == cyc) begin
            exp_out = pub_ang; exp_val = 1; pub_pend = 0;
         end
         for (int i = 0; i < sat_t.size(); i++) if (sat_t[i] <= cyc) exp_sat = 1;
         if (zr) begin
            pub_pend = 0; sat_t.delete();
            for (int k = 0; k < NCH; k++) begin
               m_ang[k] = 0; m_sum[k] = 0; exp_out[k] = 0;
            end
            exp_val = 1; m_cnt = 0; last_close = -1000;
         end else if (sv) begin
            for (int k = 0; k < NCH; k++) m_sum[k] += g_cur[k];
            m_cnt++;
            if (m_cnt == WIN) begin
               m_cnt = 0;
               if (cyc - last_close <= LAT) exp_ovr = 1;
               else begin
                  last_close = cyc; pub_pend = 1; pub_time = cyc + LAT;
                  for (int k = 0; k < NCH; k++) begin
                     d = (longint'(m_sum[k]) * MULV) >>> SH;
                     if (d > FULL - 1) begin
                        d = FULL - 1; sat_t.push_back(cyc + 1 + 2 * k);
                     end else if (d < -(FULL - 1)) begin
                        d = -(FULL - 1); sat_t.push_back(cyc + 1 + 2 * k);
                     end
                     m_ang[k]   = int'(((longint'(m_ang[k]) + d) % FULL + FULL) % FULL);
                     pub_ang[k] = m_ang[k] >> FR;
                  end
               end
               for (int k = 0; k < NCH; k++) m_sum[k] = 0;
            end
         end
      end
   end

   function automatic logic [NCH*9-1:0] pack(input int v [NCH]);
      logic [NCH*9-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*9 +: 9] = 9'(v[k]);
      return r;
   endfunction

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         vec++;
         if (aout !== pack(exp_out) || aval !== exp_val || sat !== exp_sat || ovr !== exp_ovr) begin
            miss++;
            $display("FAIL cycle %0d: angle_out=%h valid=%b sat=%b ovr=%b, required %h %b %b %b",
                     cyc, aout, aval, sat, ovr, pack(exp_out), exp_val, exp_sat, exp_ovr);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit v, input int a, input int b, input int c, input bit z);
      @(negedge clk);
      if (aval) pulses++;
      sv = v; zr = z;
      g_cur = '{a, b, c};
      gyro = {IW'(c), IW'(b), IW'(a)};
   endtask

   task automatic wait_pub(output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (aval) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         vec++; miss++;
         $display("FAIL publish_timeout: got no valid pulse, required one within 30 cycles");
      end
   endtask

   function automatic int rnd(input int m);
      return int'($urandom_range(2 * m)) - m;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, dp;
      repeat (3) @(negedge clk);
      chk("reset_angle", int'(aout), 0);
      chk("reset_valid", int'(aval), 0);
      chk("reset_sat", int'(sat), 0);
      chk("reset_ovr", int'(ovr), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // basic: 8 x +5 on ch0
      for (int i = 0; i < WIN; i++) step(1, 5, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      wait_pub(lat);
      chk("basic_latency", lat, 7);
      chk("basic_angle", int'(aout), 40);

      // wrap upward: 10 windows of +35 then +16
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
      for (int w = 0; w < 10; w++)
         for (int i = 0; i < WIN; i++) step(1, (i == WIN - 1) ? 7 : 4, rnd(20), rnd(20), 0);
      for (int i = 0; i < WIN; i++) step(1, 2, rnd(20), rnd(20), 0);
      step(0, 0, 0, 0, 0);
      wait_pub(lat);
      chk("wrap_up_ch0", int'(aout[8:0]), 6);

      // wrap downward
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
      for (int i = 0; i < WIN; i++) step(1, -8, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      wait_pub(lat);
      chk("wrap_down_ch0", int'(aout[8:0]), 296);

      // saturation
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
      for (int i = 0; i < WIN; i++) step(1, 100, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      wait_pub(lat);
      chk("sat_ch0", int'(aout[8:0]), 359);
      chk("sat_flag", int'(sat), 1);

      // back-to-back windows, nothing lost
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 3 * WIN; i++) step(1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("cont_pulses", pulses, 3);
      chk("cont_ch0", int'(aout[8:0]), 24);
      chk("cont_ovr", int'(ovr), 0);
      chk("sat_sticky", int'(sat), 1);

      // zero while processing ch1
      step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
      for (int i = 0; i < WIN; i++) step(1, 10, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("zero_valid", int'(aval), 1);
      chk("zero_angle", int'(aout), 0);
      pulses = 0;
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
      chk("abort_pulses", pulses, 0);
      chk("abort_angle", int'(aout), 0);

      // async reset mid-window with a nonzero published angle
      for (int i = 0; i < WIN; i++) step(1, 9, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      wait_pub(lat);
      for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_angle", int'(aout), 0);
      chk("async_rst_valid", int'(aval), 0);
      chk("async_rst_sat", int'(sat), 0);
      chk("async_rst_ovr", int'(ovr), 0);
      step(0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < WIN; i++) step(1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);

      // random traffic against the model
      for (int i = 0; i < 500; i++)
         step($urandom_range(9) < 7, rnd(60), rnd(60), rnd(60), $urandom_range(99) == 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

      // default parameters: 10000 x 1000 on ch0
      dp = 0;
`ifdef GYRO_BIAS_CAL_EN
      @(negedge clk); d_cal = 1'b1;
      @(negedge clk); d_cal = 1'b0;
      chk("cal_busy_set", int'(d_busy), 1);
      d_gyro = {16'd0, 16'd0, 16'd1000}; d_sv = 1'b1;
      repeat (10000) begin
         @(negedge clk);
         if (d_aval) dp++;
      end
      d_sv = 1'b0;
      chk("cal_busy_clear", int'(d_busy), 0);
      chk("cal_no_pulse", dp, 0);
`endif
      @(negedge clk);
      d_gyro = {16'd0, 16'd0, 16'd1000}; d_sv = 1'b1;
      repeat (10000) @(negedge clk);
      d_sv = 1'b0;
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (d_aval) begin
            lat = n;
            break;
         end
      end
      chk("def_latency", lat, 7);
`ifdef GYRO_BIAS_CAL_EN
      chk("def_ch0", int'(d_aout[8:0]), 0);
`else
      chk("def_ch0", int'(d_aout[8:0]), 4);
`endif
      chk("def_others", int'(d_aout[26:9]), 0);
      chk("def_sat", int'(d_sat), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
- Parametrised N-channel rate-gyro integrator; successor to the fixed 3-axis windowed gyro processor.
- Sums raw signed rate samples over a window of WINDOW accepted samples, then scales the sum to a degree delta. Adds the delta to a persistent per-channel angle kept modulo 360 with fractional bits, and publishes integer angles with a valid strobe.
- Sits between the IMU sample interface and the view-vector trig stage.
- Unlike its predecessor: angle persists across windows, samples are gated by a strobe, no samples are lost during processing, the delta saturates, and an explicit re-zero is provided.

Parameters:
- NUM_CH, 3, number of gyro channels.
- IN_W, 16, width of each signed rate sample.
- WINDOW, 10000, accepted samples per integration window; must be >= 2*NUM_CH+2.
- SCALE_MUL, 7, unsigned scale multiplier.
- SCALE_SHIFT, 16, arithmetic right shift applied after the multiply.
- FRAC_W, 8, fractional bits of the internal angle.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- gyro_in  in  NUM_CH*IN_W  packed signed samples; channel k occupies bits [k*IN_W +: IN_W].
- sample_valid_in  in  1  qualifies gyro_in for one cycle.
- zero_in  in  1  synchronous re-zero request.
- angle_out  out  NUM_CH*9  packed integer angles in 0..359; channel k occupies bits [k*9 +: 9].
- angle_valid_out  out  1  one-cycle pulse when angle_out updates.
- sat_out  out  1  sticky flag: a delta was clamped.
- overrun_out  out  1  sticky flag: a window closed while the previous window was still processing.

Behaviour:
- Reset (async assert, sync release): all accumulators, snapshots, angles, window count, angle_out, angle_valid_out, sat_out and overrun_out = 0; state = IDLE.
- Accumulators: signed, ACC_W = IN_W + $clog2(WINDOW) + 1 bits. On each sample_valid_in, acc[k] += sign-extended gyro_in[k] and the window count increments.
- Window close: the sample that brings the count to WINDOW is added in that same cycle. On the next edge, acc is copied to the snapshot, acc and count clear to 0, and the FSM enters MUL with ch = 0.
- Accumulation continues during processing. A sample arriving in the cycle after close goes into the fresh accumulator. No sample is dropped.
- FSM states: IDLE -> MUL -> WRAP -> (ch+1 < NUM_CH ? MUL : PUBLISH) -> IDLE.
  - MUL: prod = snap[ch] * SCALE_MUL (signed). delta = prod >>> SCALE_SHIFT, interpreted as degrees with FRAC_W fraction bits.
  - Clamp: delta is limited to +/-(360<<FRAC_W)-1. If clamped, sat_out <= 1.
  - WRAP: s = angle[ch] + delta. If s < 0, angle = s + (360<<FRAC_W). Else if s >= 360<<FRAC_W, angle = s - (360<<FRAC_W). Else angle = s. Angle is unsigned in [0, 360<<FRAC_W).
  - PUBLISH: angle_out[k] = angle[k] >> FRAC_W for all k, updated together. angle_valid_out = 1 for this cycle only.
- Latency: PUBLISH occurs 2*NUM_CH+1 cycles after the closing-sample edge.
- angle_out holds its value between publishes.
- Overrun: if a window closes while the FSM is not IDLE, overrun_out <= 1 and that window's sum is discarded. The count and accumulators still clear.
- zero_in (highest priority):
  - Clears angles, accumulators, snapshots and count, and forces IDLE. Any in-flight processing is aborted with no valid pulse.
  - Next cycle, angle_out = 0 with angle_valid_out = 1.
  - A sample in the same cycle as zero_in is dropped.
  - sat_out and overrun_out are cleared only by reset.

Optional Feature:
- Macro GYRO_BIAS_CAL_EN.
- When defined:
  - Adds input cal_start_in (1b) and output cal_busy_out (1b).
  - A cal_start_in pulse forces zero_in behaviour and sets cal_busy_out.
  - The next window is not integrated. Instead, bias[k] = snap[k] / WINDOW (signed, truncating toward zero) is latched and cal_busy_out clears, with no valid pulse.
  - Thereafter each accepted sample is sample - bias[k].
- When undefined: no extra ports, and bias is effectively 0.

Test Plan:
- Reset: NUM_CH=3, WINDOW=8, SCALE_MUL=1, SCALE_SHIFT=0, FRAC_W=0, rst_n_in low mid-window -> all outputs 0 immediately, with no clock edge required.
- Basic (same params): ch0=5 for 8 valid samples -> angle_valid_out pulses exactly 7 cycles after the closing-sample edge; ch0 angle = 40, others 0.
- Wrap (same params): ch0 pre-set to 350 (via windows of +35 x10) + window of 8x(+2)=16 -> ch0 = 6. Negative: from 0, 8x(-8) -> 296.
- Saturation (same params): 8x(+100)=800 -> ch0 = 359, sat_out = 1 and stays high.
- Overrun and no-loss (same params):
  - Valid held continuously -> every window published, no overrun, total of 3 windows of +1 = 24.
  - WINDOW=8 with NUM_CH=4 is illegal; instead force zero_in mid-MUL -> no pulse, next cycle angle_out = 0 with valid.
- Defaults: ch0=1000 for 10000 samples -> delta = (10,000,000*7)>>>16 = 1068 q8 -> angle_out ch0 = 4. Under GYRO_BIAS_CAL_EN, a calibration window at constant 1000 followed by the same stimulus -> angle 0.
